// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM instruction sequencer: opcodes, instruction
// field layout and controller FSM states.
package gemm_pkg;

  localparam logic [2:0] OpGemm   = 3'd2;
  localparam logic [2:0] OpFinish = 3'd3;

  // Bit positions inside the 128-bit instruction word.
  localparam int unsigned OpLsb       = 0;
  localparam int unsigned PopPrevBit  = 3;
  localparam int unsigned PopNextBit  = 4;
  localparam int unsigned PushPrevBit = 5;
  localparam int unsigned PushNextBit = 6;
  localparam int unsigned ResetRegBit = 7;
  localparam int unsigned UopBgnLsb   = 8;
  localparam int unsigned UopEndLsb   = 21;
  localparam int unsigned IterOutLsb  = 35;
  localparam int unsigned IterInLsb   = 49;
  localparam int unsigned InsnUsedMsb = 62;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StExec,
    StPush
  } gemm_state_e;

endpackage

// File: rtl/gemm_loop_cnt.sv
// Three-level micro-op loop nest (upc inner, iter_in, iter_out outer) with
// stall-aware stepping, first/last flags and zero-trip detection.
module gemm_loop_cnt #(
  parameter int unsigned UPC_WIDTH  = 13,
  parameter int unsigned ITER_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [UPC_WIDTH-1:0]  cfg_bgn,
  input  logic [UPC_WIDTH:0]    cfg_end,
  input  logic [ITER_WIDTH-1:0] cfg_iter_in,
  input  logic [ITER_WIDTH-1:0] cfg_iter_out,
  output logic [UPC_WIDTH-1:0]  upc,
  output logic [ITER_WIDTH-1:0] iter_in,
  output logic [ITER_WIDTH-1:0] iter_out,
  output logic                  first,
  output logic                  last,
  output logic                  zero_trip
);

  logic [UPC_WIDTH-1:0]  bgn_q, upc_q;
  logic [UPC_WIDTH:0]    end_q;
  logic [ITER_WIDTH-1:0] iin_cfg_q, iout_cfg_q, iin_q, iout_q;
  logic                  first_q;

  logic [UPC_WIDTH:0]    upc_inc;
  logic [ITER_WIDTH:0]   iin_inc, iout_inc;
  logic                  upc_wrap, iin_wrap, iout_wrap;

  // Compares are widened by one bit so a bound at the counter's maximum is reachable.
  assign upc_inc   = {1'b0, upc_q} + (UPC_WIDTH+1)'(1);
  assign iin_inc   = {1'b0, iin_q} + (ITER_WIDTH+1)'(1);
  assign iout_inc  = {1'b0, iout_q} + (ITER_WIDTH+1)'(1);
  assign upc_wrap  = upc_inc == end_q;
  assign iin_wrap  = iin_inc == {1'b0, iin_cfg_q};
  assign iout_wrap = iout_inc == {1'b0, iout_cfg_q};

  assign upc       = upc_q;
  assign iter_in   = iin_q;
  assign iter_out  = iout_q;
  assign first     = first_q;
  assign last      = upc_wrap & iin_wrap & iout_wrap;
  assign zero_trip = (end_q <= {1'b0, bgn_q}) | (iin_cfg_q == '0) | (iout_cfg_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bgn_q      <= '0;
      end_q      <= '0;
      iin_cfg_q  <= '0;
      iout_cfg_q <= '0;
      upc_q      <= '0;
      iin_q      <= '0;
      iout_q     <= '0;
      first_q    <= 1'b0;
    end else if (load) begin
      bgn_q      <= cfg_bgn;
      end_q      <= cfg_end;
      iin_cfg_q  <= cfg_iter_in;
      iout_cfg_q <= cfg_iter_out;
      upc_q      <= cfg_bgn;
      iin_q      <= '0;
      iout_q     <= '0;
      first_q    <= 1'b1;
    end else if (step) begin
      first_q <= 1'b0;
      if (!upc_wrap) begin
        upc_q <= upc_inc[UPC_WIDTH-1:0];
      end else begin
        upc_q <= bgn_q;
        if (!iin_wrap) begin
          iin_q <= iin_inc[ITER_WIDTH-1:0];
        end else begin
          iin_q <= '0;
          if (!iout_wrap) iout_q <= iout_inc[ITER_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/gemm_ctrl.sv
// GEMM instruction sequencer: instruction handshake, dependency tokens and micro-op issue.
// Token handling is built only when GEMM_CTRL_DEP_EN is defined; otherwise POP/PUSH pass through.
module gemm_ctrl
  import gemm_pkg::*;
#(
  parameter int unsigned INS_WIDTH  = 128,
  parameter int unsigned UPC_WIDTH  = 13,
  parameter int unsigned ITER_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insn_valid,
  output logic                  insn_ready,
  input  logic [INS_WIDTH-1:0]  insn,
  input  logic                  l2g_dep_valid,
  output logic                  l2g_dep_ready,
  input  logic                  s2g_dep_valid,
  output logic                  s2g_dep_ready,
  output logic                  g2l_dep_valid,
  input  logic                  g2l_dep_ready,
  output logic                  g2s_dep_valid,
  input  logic                  g2s_dep_ready,
  input  logic                  stall,
  output logic                  uop_valid,
  output logic [UPC_WIDTH-1:0]  uop_upc,
  output logic [ITER_WIDTH-1:0] uop_iter_in,
  output logic [ITER_WIDTH-1:0] uop_iter_out,
  output logic                  uop_reset,
  output logic                  uop_first,
  output logic                  uop_last,
  output logic                  finish,
  output logic                  done,
  output logic                  err
);

`ifdef GEMM_CTRL_DEP_EN
  localparam logic DepEn = 1'b1;
`else
  localparam logic DepEn = 1'b0;
`endif

  gemm_state_e state_q, state_d;

  logic pop_prev_q, pop_next_q, push_prev_q, push_next_q;
  logic reset_q, done_q, finish_q, err_q;
  logic accept, is_gemm, is_finish, is_bad, pop_ok, push_ok, step;
  logic cnt_first, cnt_last, zero_trip;
  logic [UPC_WIDTH-1:0]  cnt_upc;
  logic [ITER_WIDTH-1:0] cnt_iin, cnt_iout;
  logic [2:0]            opcode;
  logic                  unused_insn;

  assign opcode      = insn[OpLsb +: 3];
  assign is_gemm     = opcode == OpGemm;
  assign is_finish   = opcode == OpFinish;
  assign is_bad      = !is_gemm && !is_finish;
  assign unused_insn = ^insn[INS_WIDTH-1:InsnUsedMsb+1];

  assign insn_ready = (state_q == StIdle) && !rst;
  assign accept     = insn_valid && insn_ready;

  // Pending flags are only ever set with DepEn, so without it the token ports stay at 0.
  assign l2g_dep_ready = (state_q == StPop) && pop_prev_q;
  assign s2g_dep_ready = (state_q == StPop) && pop_next_q;
  assign g2l_dep_valid = (state_q == StPush) && push_prev_q;
  assign g2s_dep_valid = (state_q == StPush) && push_next_q;
  assign pop_ok  = (!pop_prev_q || l2g_dep_valid) && (!pop_next_q || s2g_dep_valid);
  assign push_ok = (!push_prev_q || g2l_dep_ready) && (!push_next_q || g2s_dep_ready);

  assign uop_valid    = state_q == StExec;
  assign step         = uop_valid && !stall;
  assign uop_upc      = uop_valid ? cnt_upc : '0;
  assign uop_iter_in  = uop_valid ? cnt_iin : '0;
  assign uop_iter_out = uop_valid ? cnt_iout : '0;
  assign uop_reset    = uop_valid && reset_q;
  assign uop_first    = uop_valid && cnt_first;
  assign uop_last     = uop_valid && cnt_last;

  assign finish = finish_q;
  assign done   = done_q;
  assign err    = err_q;

  gemm_loop_cnt #(
    .UPC_WIDTH (UPC_WIDTH),
    .ITER_WIDTH(ITER_WIDTH)
  ) u_loop_cnt (
    .clk         (clk),
    .rst         (rst),
    .load        (accept && is_gemm),
    .step        (step),
    .cfg_bgn     (insn[UopBgnLsb +: UPC_WIDTH]),
    .cfg_end     (insn[UopEndLsb +: UPC_WIDTH+1]),
    .cfg_iter_in (insn[IterInLsb +: ITER_WIDTH]),
    .cfg_iter_out(insn[IterOutLsb +: ITER_WIDTH]),
    .upc         (cnt_upc),
    .iter_in     (cnt_iin),
    .iter_out    (cnt_iout),
    .first       (cnt_first),
    .last        (cnt_last),
    .zero_trip   (zero_trip)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && is_gemm) state_d = StPop;
        else if (accept && is_finish) state_d = StPush;
      end
      StPop:   if (pop_ok) state_d = zero_trip ? StPush : StExec;
      StExec:  if (step && cnt_last) state_d = StPush;
      StPush:  if (push_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_prev_q  <= 1'b0;
      pop_next_q  <= 1'b0;
      push_prev_q <= 1'b0;
      push_next_q <= 1'b0;
      reset_q     <= 1'b0;
      done_q      <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q   <= (accept && is_bad) || ((state_q == StPush) && push_ok);
      finish_q <= accept && is_finish;
      if (accept && is_bad) err_q <= 1'b1;
      if (accept) begin
        pop_prev_q  <= DepEn && is_gemm && insn[PopPrevBit];
        pop_next_q  <= DepEn && is_gemm && insn[PopNextBit];
        push_prev_q <= DepEn && !is_bad && insn[PushPrevBit];
        push_next_q <= DepEn && !is_bad && insn[PushNextBit];
        reset_q     <= insn[ResetRegBit];
      end else begin
        if (l2g_dep_valid && l2g_dep_ready) pop_prev_q <= 1'b0;
        if (s2g_dep_valid && s2g_dep_ready) pop_next_q <= 1'b0;
        if (g2l_dep_valid && g2l_dep_ready) push_prev_q <= 1'b0;
        if (g2s_dep_valid && g2s_dep_ready) push_next_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gemm_ctrl.sv
// Self-checking bench for gemm_ctrl: instruction vector table with a micro-op scoreboard,
// plus hand-written token, backpressure and reset sequences (token checks follow GEMM_CTRL_DEP_EN).
module tb_gemm_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         insn_valid, insn_ready;
  logic [127:0] insn;
  logic         l2g_dep_valid, l2g_dep_ready, s2g_dep_valid, s2g_dep_ready;
  logic         g2l_dep_valid, g2l_dep_ready, g2s_dep_valid, g2s_dep_ready;
  logic         stall, uop_valid, uop_reset, uop_first, uop_last, finish, done, err;
  logic [12:0]  uop_upc;
  logic [13:0]  uop_iter_in, uop_iter_out;

  gemm_ctrl #(
    .INS_WIDTH (128),
    .UPC_WIDTH (13),
    .ITER_WIDTH(14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn         (insn),
    .l2g_dep_valid(l2g_dep_valid),
    .l2g_dep_ready(l2g_dep_ready),
    .s2g_dep_valid(s2g_dep_valid),
    .s2g_dep_ready(s2g_dep_ready),
    .g2l_dep_valid(g2l_dep_valid),
    .g2l_dep_ready(g2l_dep_ready),
    .g2s_dep_valid(g2s_dep_valid),
    .g2s_dep_ready(g2s_dep_ready),
    .stall        (stall),
    .uop_valid    (uop_valid),
    .uop_upc      (uop_upc),
    .uop_iter_in  (uop_iter_in),
    .uop_iter_out (uop_iter_out),
    .uop_reset    (uop_reset),
    .uop_first    (uop_first),
    .uop_last     (uop_last),
    .finish       (finish),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [2:0] op;
    bit       pop_prev, pop_next, push_prev, push_next, rr;
    int       bgn, uend, iin, iout;
    bit       stall_en, exp_err, exp_fin;
  } vec_t;

  logic [63:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, hs_cyc = 0, first_cyc = 0, n_uop = 0;
  bit got_first = 0, stall_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [63:0] pack_uop(input logic [12:0] u, input logic [13:0] ii,
                                           input logic [13:0] io, input logic f, input logic l,
                                           input logic r);
    return {20'b0, u, ii, io, f, l, r};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({insn_ready, uop_valid, uop_upc, uop_iter_in, uop_iter_out, uop_reset, uop_first,
                uop_last, finish, done, err, l2g_dep_ready, s2g_dep_ready, g2l_dep_valid,
                g2s_dep_valid});
  endfunction

  function automatic vec_t mk(input bit [2:0] op, input int bgn, input int uend, input int iin,
                              input int iout, input bit [3:0] tok, input bit rr, input bit st,
                              input bit e, input bit f);
    vec_t v;
    v.op = op; v.bgn = bgn; v.uend = uend; v.iin = iin; v.iout = iout;
    {v.pop_prev, v.pop_next, v.push_prev, v.push_next} = tok;
    v.rr = rr; v.stall_en = st; v.exp_err = e; v.exp_fin = f;
    return v;
  endfunction

  function automatic logic [127:0] make_insn(input vec_t v);
    logic [127:0] w;
    w        = '0;
    w[2:0]   = v.op;
    w[3]     = v.pop_prev;
    w[4]     = v.pop_next;
    w[5]     = v.push_prev;
    w[6]     = v.push_next;
    w[7]     = v.rr;
    w[20:8]  = 13'(v.bgn);
    w[34:21] = 14'(v.uend);
    w[48:35] = 14'(v.iout);
    w[62:49] = 14'(v.iin);
    return w;
  endfunction

  // Reference loop nest: iter_out outer, iter_in middle, upc inner.
  function automatic int model_push(input vec_t v);
    int n = 0;
    int total;
    if (v.op != 3'd2) return 0;
    total = ((v.uend > v.bgn) ? (v.uend - v.bgn) : 0) * v.iin * v.iout;
    for (int o = 0; o < v.iout; o++)
      for (int i = 0; i < v.iin; i++)
        for (int u = v.bgn; u < v.uend; u++) begin
          exp_q.push_back(pack_uop(13'(u), 14'(i), 14'(o), n == 0, n == total - 1, v.rr));
          n++;
        end
    return n;
  endfunction

  // Scoreboard: each cycle a uop is presented it must equal the queue head; pop on consume.
  always @(negedge clk) begin
    if (!rst && uop_valid) begin
      if (!got_first) begin
        got_first = 1;
        first_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL uop_unexpected: got upc %0d, expected no micro-op", uop_upc);
      end else begin
        chk("uop", pack_uop(uop_upc, uop_iter_in, uop_iter_out, uop_first, uop_last, uop_reset),
            exp_q[0]);
        if (!stall) begin
          void'(exp_q.pop_front());
          n_uop++;
        end
      end
    end
`ifndef GEMM_CTRL_DEP_EN
    if (!rst) chk("dep_tied", 64'({l2g_dep_ready, s2g_dep_ready, g2l_dep_valid, g2s_dep_valid}),
                  64'd0);
`endif
  end

  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1 stall = stall_en && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic issue(input vec_t v);
    int t = 0;
    got_first  = 0;
    n_uop      = 0;
    insn       = make_insn(v);
    insn_valid = 1'b1;
    @(negedge clk);
    while (!insn_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("insn_accept", 64'(insn_ready), 64'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1 insn_valid = 1'b0;
  endtask

  task automatic wait_done(input vec_t v, input int n_exp, input bit chk_lat);
    int t = 0;
    int n_fin = 0;
    bit seen = 0;
    while (!seen && t < 2000) begin
      @(negedge clk);
      t++;
      if (finish) n_fin++;
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("done_single", 64'(done), 64'd0);
      if (finish) n_fin++;
    end
    stall_en = 0;
    chk("finish_cnt", 64'(n_fin), 64'(v.exp_fin));
    chk("err", 64'(err), 64'(v.exp_err));
    chk("uop_count", 64'(n_uop), 64'(n_exp));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    if (n_exp > 0 && chk_lat) chk("first_latency", 64'(first_cyc - hs_cyc), 64'd2);
    if (n_exp == 0) chk("no_uop", 64'(got_first), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int   n, t;
    bit   seen;

    tbl[0] = mk(3'd2, 4, 7, 2, 3, 4'b0000, 0, 0, 0, 0);
    tbl[1] = mk(3'd2, 4, 7, 2, 3, 4'b0000, 0, 1, 0, 0);
    tbl[2] = mk(3'd2, 0, 1, 1, 1, 4'b1111, 1, 0, 0, 0);
    tbl[3] = mk(3'd2, 10, 12, 3, 1, 4'b0001, 0, 1, 0, 0);
    tbl[4] = mk(3'd2, 4, 7, 0, 2, 4'b0010, 0, 0, 0, 0);
    tbl[5] = mk(3'd2, 5, 5, 2, 2, 4'b0000, 0, 0, 0, 0);
    tbl[6] = mk(3'd3, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1);
    tbl[7] = mk(3'd5, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
    tbl[8] = mk(3'd2, 2, 5, 1, 2, 4'b0000, 1, 0, 1, 0);

    rst = 1'b1;
    insn_valid = 1'b0;
    insn = '0;
    l2g_dep_valid = 1'b1;
    s2g_dep_valid = 1'b1;
    g2l_dep_ready = 1'b1;
    g2s_dep_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(insn_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 9; k++) begin
      n = model_push(tbl[k]);
      stall_en = tbl[k].stall_en;
      issue(tbl[k]);
      wait_done(tbl[k], n, 1);
    end

`ifdef GEMM_CTRL_DEP_EN
    // Store token arrives five cycles before the load token.
    l2g_dep_valid = 1'b0;
    s2g_dep_valid = 1'b0;
    v = mk(3'd2, 0, 2, 1, 1, 4'b1100, 0, 0, 1, 0);
    n = model_push(v);
    issue(v);
    repeat (3) begin
      @(negedge clk);
      chk("pop_wait", 64'({l2g_dep_ready, s2g_dep_ready, uop_valid}), 64'b110);
    end
    @(posedge clk);
    #1 s2g_dep_valid = 1'b1;
    @(negedge clk);
    chk("s2g_hs", 64'({l2g_dep_ready, s2g_dep_ready, uop_valid}), 64'b110);
    @(posedge clk);
    #1 s2g_dep_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("s2g_cleared", 64'({l2g_dep_ready, s2g_dep_ready, uop_valid}), 64'b100);
      @(posedge clk);
      #1;
    end
    l2g_dep_valid = 1'b1;
    @(negedge clk);
    chk("l2g_hs", 64'({l2g_dep_ready, s2g_dep_ready, uop_valid}), 64'b100);
    @(posedge clk);
    #1 l2g_dep_valid = 1'b0;
    @(negedge clk);
    chk("exec_after_pop", 64'({l2g_dep_ready, s2g_dep_ready, uop_valid}), 64'b001);
    wait_done(v, n, 0);

    // Store stage holds off the push token for four cycles.
    g2s_dep_ready = 1'b0;
    v = mk(3'd2, 0, 1, 1, 1, 4'b0001, 0, 0, 1, 0);
    n = model_push(v);
    issue(v);
    t = 0;
    seen = 0;
    while (!seen && t < 100) begin
      @(negedge clk);
      t++;
      seen = g2s_dep_valid;
    end
    chk("push_valid_seen", 64'(seen), 64'd1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("push_hold", 64'({g2s_dep_valid, done}), 64'b10);
    end
    @(posedge clk);
    #1 g2s_dep_ready = 1'b1;
    @(negedge clk);
    chk("push_hs", 64'({g2s_dep_valid, done}), 64'b10);
    @(posedge clk);
    #1 g2s_dep_ready = 1'b0;
    @(negedge clk);
    chk("push_done", 64'({g2s_dep_valid, done}), 64'b01);
    chk("push_uops", 64'(n_uop), 64'(n));
    @(posedge clk);
    #1;
    l2g_dep_valid = 1'b1;
    s2g_dep_valid = 1'b1;
    g2s_dep_ready = 1'b1;
`else
    // Token fields must be ignored even with no token traffic at all.
    l2g_dep_valid = 1'b0;
    s2g_dep_valid = 1'b0;
    g2l_dep_ready = 1'b0;
    g2s_dep_ready = 1'b0;
    v = mk(3'd2, 0, 3, 1, 1, 4'b1111, 0, 0, 1, 0);
    n = model_push(v);
    issue(v);
    wait_done(v, n, 1);
`endif

    // Reset in the middle of a long instruction.
    v = mk(3'd2, 0, 7, 2, 3, 4'b0000, 0, 0, 0, 0);
    n = model_push(v);
    issue(v);
    t = 0;
    while (!uop_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("exec_reached", 64'(uop_valid), 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1 chk("midrst_outputs", outs(), 64'd0);
    @(negedge clk);
    chk("midrst_hold", outs(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(insn_ready), 64'd1);
    chk("midrst_err_clear", 64'(err), 64'd0);
    @(posedge clk);
    #1;

    l2g_dep_valid = 1'b1;
    s2g_dep_valid = 1'b1;
    g2l_dep_ready = 1'b1;
    g2s_dep_ready = 1'b1;
    n = model_push(tbl[0]);
    issue(tbl[0]);
    wait_done(tbl[0], n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gemm_ctrl.md
# gemm_ctrl

Instruction-level sequencer for the GEMM core. Accepts one 128-bit GEMM instruction at a time over a valid/ready handshake and resolves its dependency tokens with the load and store stages. It then issues the full micro-op loop nest (upc × iter_in × iter_out) to the micro-op fetch/index datapath under stall backpressure, and finally pushes completion tokens. It sits between the instruction queue and the micro-op fetch/GEMM datapath.

## Interface
- INS_WIDTH, 128, instruction width
- UPC_WIDTH, 13, micro-op counter width
- ITER_WIDTH, 14, loop counter width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- insn_valid / insn_ready  in / out  1  instruction handshake
- insn  in  INS_WIDTH  instruction (opcode[2:0], pop_prev[3], pop_next[4], push_prev[5], push_next[6], reset_reg[7], uop_bgn[20:8], uop_end[34:21], iter_out[48:35], iter_in[62:49])
- l2g_dep_valid / l2g_dep_ready  in / out  1  token from load stage (pop_prev)
- s2g_dep_valid / s2g_dep_ready  in / out  1  token from store stage (pop_next)
- g2l_dep_valid / g2l_dep_ready  out / in  1  token to load stage (push_prev)
- g2s_dep_valid / g2s_dep_ready  out / in  1  token to store stage (push_next)
- stall  in  1  datapath backpressure; holds the current micro-op
- uop_valid  out  1  micro-op issue strobe
- uop_upc  out  UPC_WIDTH  current micro-op index
- uop_iter_in / uop_iter_out  out  ITER_WIDTH  current loop indices
- uop_reset  out  1  latched reset_reg (datapath zeroes accumulators instead of MAC)
- uop_first / uop_last  out  1  first / last micro-op of the instruction
- finish  out  1  one-cycle pulse on a FINISH instruction (opcode 3)
- done  out  1  one-cycle pulse when an instruction retires
- err  out  1  sticky; set on an unsupported opcode

## Operation
- FSM states: IDLE, POP, EXEC, PUSH.
- IDLE: insn_ready=1. On handshake, latch insn.
  - opcode 2 (GEMM) -> POP.
  - opcode 3 -> finish pulse, go to PUSH (tokens honoured).
  - Any other opcode -> set err, retire with done, stay IDLE.
- POP: per-token pending flags are loaded from pop_prev/pop_next. Drive l2g_dep_ready / s2g_dep_ready while the matching flag is pending. Each flag clears on its handshake; the two may complete in the same cycle or separately.
  - When no flag is pending -> EXEC. A zero-trip instruction (uop_end<=uop_bgn, iter_in==0 or iter_out==0) goes to PUSH instead.
- EXEC: uop_valid=1. A micro-op is consumed on uop_valid&&!stall.
  - Advance order: upc++; on upc+1==uop_end, upc<=uop_bgn and iter_in++; on iter_in wrap, iter_in<=0 and iter_out++.
  - uop_last = (upc+1==uop_end)&&(iter_in+1==iter_in_cfg)&&(iter_out+1==iter_out_cfg).
  - Consuming the last micro-op -> PUSH.
- PUSH: assert g2l_dep_valid / g2s_dep_valid per push_prev/push_next. Each valid holds until its ready is seen, then drops. When all pushes are complete -> done pulse, IDLE.
- Counter compares are full width with zero extension; no counter wraps past its configured bound.

## Timing
- Reset values:
  - FSM=IDLE; insn_ready=0 during reset, 1 the first cycle after.
  - All valids, readies, uop_* outputs, done, finish and err = 0.
- First uop_valid: 1 cycle after POP completes. With no pops, 2 cycles after the insn handshake.
- Issue rate: 1 micro-op/cycle when stall=0. Under stall, all uop_* outputs stay stable.
- EXEC -> PUSH -> IDLE: done occurs ≥1 cycle after the last micro-op. The next instruction can be accepted the cycle after done.
- Reset mid-operation returns to IDLE. Any held or pending tokens are discarded and err clears.

## Configuration
- GEMM_CTRL_DEP_EN defined: dependency token handling as above.
- GEMM_CTRL_DEP_EN undefined:
  - Token fields are ignored. All *_dep_ready / *_dep_valid are tied to 0.
  - POP and PUSH each pass through in one cycle, keeping the latency numbers above.

## Structure
- Shared package (gemm_pkg): opcode constants (GEMM=2, FINISH=3), instruction field bit positions/widths, FSM state enum.
- Sub-module gemm_loop_cnt: the three-level nested counter with stall, first/last and zero-trip detection. The FSM and handshakes stay in gemm_ctrl.

## Test plan
- GEMM: bgn=4, end=7, iter_in=2, iter_out=3, no deps, stall=0 -> 18 uop_valid cycles. upc runs 4,5,6 repeating; uop_last only on (6,1,2); single done.
- pop_prev=pop_next=1: s2g_dep_valid arrives 5 cycles before l2g_dep_valid -> no uop_valid until both are consumed. Each ready is high only while pending.
- push_next=1 with g2s_dep_ready low for 4 cycles -> g2s_dep_valid held 4+1 cycles; done one cycle after the handshake.
- Random stall at 50% during the first GEMM case -> identical uop sequence, outputs stable while stalled.
- iter_in=0 -> no uop_valid; pushes still occur; done. Opcode 5 -> err=1, done, next instruction accepted.
- rst asserted mid-EXEC -> all outputs 0 immediately, insn_ready=1 the cycle after release, err=0.
